systolic_tile_writeback: RTL
============================

Name: systolic_tile_writeback

Overview:
- Downstream consumer of the systolic-array driver: captures the finished 8x8 result tile when the driver signals done.
- Streams the tile to memory row-major, BANDWIDTH words per write beat, with waitrequest back-pressure.
- Single-tile capture buffer, so the driver may start the next tile as soon as capture completes.

Parameters:
- TILE_DIM, 8, tile edge in elements; must be a multiple of BANDWIDTH.
- BEATS_PER_ROW, TILE_DIM/BANDWIDTH (2), write beats per tile row; derived, not overridable.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- tile_valid  input  1  tile, base_C and dim_col_C are valid this cycle; driven by the driver's done.
- tile  input  [7:0][7:0][DATA_WIDTH-1:0]  result tile; index [row][col].
- base_C  input  ADDR_WIDTH  word address of element (0,0).
- dim_col_C  input  DIM_WIDTH  row stride of C, in words.
- tile_ready  output  1  high when a tile can be captured.
- write  output  1  write request.
- write_addr  output  ADDR_WIDTH  word address of writedata[0].
- writedata  output  [BANDWIDTH-1:0][DATA_WIDTH-1:0]  writedata[k] is element at column offset k.
- waitrequest  input  1  memory stall; a beat is accepted when write && !waitrequest.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset, asynchronous: state=IDLE, beat counter=0, write=0, done=0, write_addr=0, writedata=0, tile_ready=1. The tile buffer is not reset.
- States:
  - IDLE: tile_ready=1. tile_valid=1 captures tile, base_C and dim_col_C; beat=0; row_addr=base_C; next state WRITE.
  - WRITE: tile_ready=0; write=1 on every cycle in this state.
    - beat[3:0] gives row=beat[3:1], half=beat[0].
    - write_addr = row_addr + half*BANDWIDTH.
    - writedata[k] = buf[row][half*BANDWIDTH+k].
    - On acceptance: beat++. If half==1, row_addr += dim_col_C (zero-extended).
    - Acceptance of beat 15 moves to DONE.
  - DONE: write=0, done=1 for exactly one cycle; next state IDLE.
- Capture latency: first write asserts the cycle after capture. With waitrequest held low, a tile takes 16 write cycles plus 1 DONE cycle. tile_ready returns high the cycle after done.
- Back-pressure: while waitrequest=1, write, write_addr and writedata are held stable and beat does not advance. No bound on stall length.
- tile_valid outside IDLE is ignored; no error is raised. The driver must not pulse done again before tile_ready.
- Simultaneous tile_valid in the DONE→IDLE transition cycle is not captured. Capture happens only when state==IDLE.
- write low implies writedata=0 and write_addr=0, which keeps traces deterministic.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- dim_col_C=0 is legal: all rows target the same addresses and the last row wins.
- Reset mid-WRITE aborts immediately. write drops asynchronously and no done is produced; a partial tile may remain in memory.
- Input tile and addresses are sampled only at capture; later changes have no effect.

Decomposition:
- Package systolic_pkg:
  - TILE_DIM=8, BEATS_PER_ROW, TILE_BEATS=16.
  - typedef wb_state_t enum {IDLE, WRITE, DONE}.
  - typedef tile_t = [TILE_DIM-1:0][TILE_DIM-1:0][DATA_WIDTH-1:0].
- DATA_WIDTH, ADDR_WIDTH, DIM_WIDTH and BANDWIDTH stay in the existing macro header.
- Address generation reuses the existing Accum block:
  - load = capture
  - en = accept && half
  - offset = dim_col_C
- The beat index reuses the existing Counter block.
- Top-level FSM and buffer stay in one module; no further sub-module.

Test Plan:
- Single tile, no stall: tile[r][c]=r*8+c, base_C=100, dim_col_C=32.
  - Required 16 writes on consecutive cycles, addresses 100,104,132,136,…,324,328.
  - Beat 0 writedata={3,2,1,0}; beat 15 writedata={63,62,61,60}.
  - done pulses on the cycle after beat 15.
- Random waitrequest (about 50%): same tile as above.
  - Outputs are stable during every stall; the accepted sequence is identical to the no-stall case.
  - done fires exactly once.
- Back-to-back: a second tile (values+64) is presented on the first cycle tile_ready rises.
  - Captured with no lost beats; 32 total writes; two done pulses.
  - tile_valid pulses during WRITE are ignored.
- Input change after capture: drive tile to all 0xFFFFFFFF one cycle after capture.
  - Written data still equals the captured values.
- Async reset at beat 7 while waitrequest=1.
  - write=0 immediately, state returns to IDLE, tile_ready=1, no done.
  - A subsequent tile writes cleanly from beat 0.
- Address wrap: base_C=2^ADDR_WIDTH-8, dim_col_C=16.
  - Beat 2 address wraps to 8; beat 3 address is 12.

Source files
------------

// File: rtl/systolic_tile_writeback_pkg.sv
// Shared widths, tile geometry and types for the systolic tile writeback path.
// Bus widths live in these guarded macros so every file sees the same values.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 8
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 4
`endif

package systolic_pkg;

  localparam int TILE_DIM      = 8;
  localparam int BEATS_PER_ROW = TILE_DIM / `BANDWIDTH;
  localparam int TILE_BEATS    = TILE_DIM * BEATS_PER_ROW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wb_state_t;

  typedef logic [TILE_DIM-1:0][TILE_DIM-1:0][`DATA_WIDTH-1:0] tile_t;

endpackage

// File: rtl/systolic_tile_writeback_accum.sv
// Loadable accumulator: load takes priority, otherwise add offset on enable.
module accum #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  input  logic [W-1:0] offset,
  output logic [W-1:0] value
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (en) begin
      value <= value + offset;
    end
  end

endmodule

// File: rtl/systolic_tile_writeback_counter.sv
// Beat index counter: synchronous clear, increment on enable, wraps naturally.
module counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/systolic_tile_writeback.sv
// Captures a finished 8x8 result tile and streams it row-major to memory,
// BANDWIDTH words per beat, honouring waitrequest back-pressure.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 8
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 4
`endif

module systolic_tile_writeback
  import systolic_pkg::*;
(
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  tile_valid,
  input  tile_t                                 tile,
  input  logic [`ADDR_WIDTH-1:0]                base_C,
  input  logic [`DIM_WIDTH-1:0]                 dim_col_C,
  output logic                                  tile_ready,
  output logic                                  write,
  output logic [`ADDR_WIDTH-1:0]                write_addr,
  output logic [`BANDWIDTH-1:0][`DATA_WIDTH-1:0] writedata,
  input  logic                                  waitrequest,
  output logic                                  done
);

  localparam int AW     = `ADDR_WIDTH;
  localparam int BW     = `BANDWIDTH;
  localparam int BEAT_W = $clog2(TILE_BEATS);
  localparam int HALF_W = $clog2(BEATS_PER_ROW);
  localparam int COL_W  = $clog2(TILE_DIM);

  wb_state_t                 state_reg;
  wb_state_t                 state_next;
  tile_t                     tile_reg;
  logic [`DIM_WIDTH-1:0]     dim_reg;
  logic [BEAT_W-1:0]         beat;
  logic [BEAT_W-HALF_W-1:0]  row;
  logic [HALF_W-1:0]         half;
  logic [COL_W-1:0]          col_base;
  logic [AW-1:0]             row_addr;
  logic                      capture;
  logic                      accept;
  logic                      last_in_row;
  logic                      last_beat;

  assign capture     = tile_valid && (state_reg == IDLE);
  assign accept      = write && !waitrequest;
  assign row         = beat[BEAT_W-1:HALF_W];
  assign half        = beat[HALF_W-1:0];
  assign last_in_row = (half == HALF_W'(BEATS_PER_ROW - 1));
  assign last_beat   = (beat == BEAT_W'(TILE_BEATS - 1));
  assign col_base    = COL_W'(half) * COL_W'(BW);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      dim_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        dim_reg <= dim_col_C;
      end
    end
  end

  // Tile storage is deliberately left out of reset; it is always overwritten on capture.
  always_ff @(posedge clock) begin
    if (capture) begin
      tile_reg <= tile;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (tile_valid) state_next = WRITE;
      WRITE:   if (accept && last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  counter #(.W(BEAT_W)) u_beat (
    .clock (clock),
    .reset (reset),
    .clear (capture),
    .en    (accept),
    .count (beat)
  );

  accum #(.W(AW)) u_row_addr (
    .clock      (clock),
    .reset      (reset),
    .load       (capture),
    .load_value (base_C),
    .en         (accept && last_in_row),
    .offset     (AW'(dim_reg)),
    .value      (row_addr)
  );

  assign tile_ready = (state_reg == IDLE);
  assign write      = (state_reg == WRITE);
  assign done       = (state_reg == DONE);
  // Address and data are forced to zero whenever no write is requested.
  assign write_addr = write ? (row_addr + AW'(half) * AW'(BW)) : '0;

  for (genvar gi = 0; gi < BW; gi++) begin : g_lane
    logic [COL_W-1:0] col;
    assign col           = col_base + COL_W'(gi);
    assign writedata[gi] = write ? tile_reg[row][col] : '0;
  end

endmodule
